mmio_rgb_timer: RTL
===================

# mmio_rgb_timer

Memory-mapped LED/RGB-PWM and millisecond-timer peripheral that sits on the processor's data-memory bus, downstream of the load/store path. It decodes word accesses in its own address window and drives the board `led`, `red`, `green`, `blue` pins that `top` exposes. It also supplies a free-running millisecond counter that programs read for delays. Accesses outside its window are ignored, so the block can run in parallel with data RAM.

## Interface
Parameters:
- `BASE_ADDR`, 32'hFFFF_FF00, word-aligned base of the 16-byte register window
- `CLKS_PER_MS`, 12000, clock cycles per millisecond tick (12 MHz board clock)
- `PWM_DIV`, 4, clock cycles per PWM counter step (≥1)

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `mem_addr`  in  32  byte address from the load/store unit
- `mem_wen`  in  1  store strobe, one cycle per store
- `mem_wmask`  in  4  byte enables; bit n qualifies `mem_wdata[8n+7:8n]`
- `mem_wdata`  in  32  store data
- `mem_rdata`  out  32  registered read data
- `mem_hit`  out  1  registered; high when the previous-cycle `mem_addr` fell in the window
- `led`  out  1  user LED, active-high
- `red`, `green`, `blue`  out  1 each  RGB LED drives, active-low

## Operation
- Window decode: `mem_addr[31:4] == BASE_ADDR[31:4]`. Offset is `mem_addr[3:2]`. `mem_addr[1:0]` is ignored.
- Registers:
  - 0x0 CTRL: bit0 `led_on`, bit1 `blink`; other bits read 0. `led = blink ? ms_count[9] : led_on`.
  - 0x4 DUTY: [7:0] R, [15:8] G, [23:16] B; [31:24] read 0.
  - 0x8 MS: 32-bit millisecond counter, read/write.
  - 0xC ID: read-only constant 32'h5247_4231; writes ignored.
- Writes honour `mem_wmask` per byte. A write with all mask bits clear has no effect.
- Prescaler:
  - `pre_cnt` counts 0..CLKS_PER_MS-1.
  - At CLKS_PER_MS-1 it returns to 0 and `ms_count` increments, wrapping 32'hFFFF_FFFF→0.
  - A write to MS loads the masked bytes into `ms_count` and clears `pre_cnt`. If a write and a tick occur in the same cycle, the write wins and the tick is lost.
- PWM:
  - `div_cnt` counts 0..PWM_DIV-1. On wrap, 8-bit `pwm_cnt` increments, wrapping 255→0.
  - Shadow duties `act_r/g/b` load from DUTY only in the cycle where `pwm_cnt` wraps 255→0, so there are no mid-period glitches.
  - Channel is on (pin driven 0) when `pwm_cnt < act_x`. Duty 0 means always off; duty 255 means on for 255 of 256 steps.
- Reads:
  - `mem_rdata` and `mem_hit` are registered from the current-cycle `mem_addr`.
  - Out-of-window reads give `mem_rdata = 0`, `mem_hit = 0`.
  - A read of MS returns the value before any same-cycle increment or write.

## Timing
- Reset state (asynchronous, immediate on `reset` high):
  - CTRL, DUTY, shadows, `ms_count`, `pre_cnt`, `div_cnt`, `pwm_cnt` = 0.
  - `led` = 0; `red`/`green`/`blue` = 1 (off); `mem_rdata` = 0; `mem_hit` = 0.
- Reset asserted mid-period or mid-count aborts everything. Counting resumes from zero on the first edge after release.
- Store: the register updates on the `clk` edge where `mem_wen` is high. `led` reflects CTRL one cycle later, because `led` is combinational from registers.
- DUTY write: takes effect at the next `pwm_cnt` 255→0 wrap, at most 256·PWM_DIV cycles later.
- Load latency: 1 cycle. Data is valid on the edge after the address is presented, which matches the processor's synchronous data-memory read.
- Back-to-back store then load to the same register returns the new value.
- The ms tick fires every CLKS_PER_MS cycles exactly; there is no drift across MS reads.

## Test plan
- Reset/ID:
  - Assert `reset` mid-run → all outputs reach the reset values above without waiting for a clock edge.
  - Read 0xFFFF_FF0C → `mem_rdata = 32'h5247_4231`, `mem_hit = 1` next cycle.
  - Read 0x0000_0010 → `mem_rdata = 0`, `mem_hit = 0`.
- LED/blink:
  - Store 0x1 to CTRL → `led = 1`.
  - Store 0x2 to CTRL with CLKS_PER_MS=4 → `led` rises after 512 ms ticks (2048 cycles) and toggles every 2048 cycles.
- Byte masking: DUTY = 0, then store 0xAABBCCDD with mask 4'b0010 → DUTY reads 0x0000_CC00.
- PWM (PWM_DIV=1):
  - DUTY R=64, G=0, B=255 → per 256-cycle period, `red` low for 64 cycles, `green` never low, `blue` low for 255 cycles.
  - A DUTY write mid-period leaves the current period unchanged.
- MS counter (CLKS_PER_MS=4):
  - Store 0xFFFF_FFFF to MS → reads 0 after 4 more cycles.
  - A store landing on the tick cycle → stored value is kept, and the next increment comes 4 cycles after the store.

Source files
------------

// File: rtl/mmio_rgb_timer.sv
// Memory-mapped LED / RGB-PWM / millisecond-timer peripheral on the data-memory bus.
// Registers: CTRL (0x0), DUTY (0x4), MS (0x8), ID (0xC); reads are registered, one cycle latency.
module mmio_rgb_timer #(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FF00,
  parameter int          CLKS_PER_MS = 12000,
  parameter int          PWM_DIV     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic        mem_wen,
  input  logic [3:0]  mem_wmask,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_hit,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  localparam int PRE_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam int DIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLKS_PER_MS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PWM_DIV - 1);
  localparam logic [31:0] ID_VALUE = 32'h5247_4231;
  localparam logic [1:0] OFF_CTRL = 2'd0;
  localparam logic [1:0] OFF_DUTY = 2'd1;
  localparam logic [1:0] OFF_MS   = 2'd2;
  localparam logic [1:0] OFF_ID   = 2'd3;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  logic [1:0]       r_ctrl;
  logic [23:0]      r_duty;
  logic [7:0]       r_act_r;
  logic [7:0]       r_act_g;
  logic [7:0]       r_act_b;
  logic [31:0]      r_ms;
  logic [PRE_W-1:0] r_pre;
  logic [DIV_W-1:0] r_div;
  logic [7:0]       r_pwm;
  logic [31:0]      r_rdata;
  logic             r_hit;

  logic        w_sel;
  logic [1:0]  w_off;
  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_duty;
  logic        w_wr_ms;
  logic        w_tick;
  logic        w_div_wrap;
  logic        w_pwm_wrap;
  logic [31:0] w_rd_mux;
  logic        w_unused_addr;

  assign w_sel         = (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign w_off         = mem_addr[3:2];
  assign w_unused_addr = ^mem_addr[1:0];
  // An all-zero byte mask is treated as no access at all, so it cannot clear the prescaler.
  assign w_wr          = mem_wen & w_sel & (|mem_wmask);
  assign w_wr_ctrl     = w_wr & (w_off == OFF_CTRL);
  assign w_wr_duty     = w_wr & (w_off == OFF_DUTY);
  assign w_wr_ms       = w_wr & (w_off == OFF_MS);

  assign w_tick     = (r_pre == PRE_LAST);
  assign w_div_wrap = (r_div == DIV_LAST);
  assign w_pwm_wrap = w_div_wrap & (r_pwm == 8'hFF);

  // Control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl <= 2'b00;
      r_duty <= 24'd0;
    end else begin
      if (w_wr_ctrl && mem_wmask[0]) r_ctrl <= mem_wdata[1:0];
      if (w_wr_duty) begin
        if (mem_wmask[0]) r_duty[7:0]   <= mem_wdata[7:0];
        if (mem_wmask[1]) r_duty[15:8]  <= mem_wdata[15:8];
        if (mem_wmask[2]) r_duty[23:16] <= mem_wdata[23:16];
      end
    end
  end

  // Millisecond prescaler and counter; a store to MS beats a coincident tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre <= '0;
      r_ms  <= 32'd0;
    end else if (w_wr_ms) begin
      r_pre <= '0;
      r_ms  <= merge_bytes(r_ms, mem_wdata, mem_wmask);
    end else if (w_tick) begin
      r_pre <= '0;
      r_ms  <= r_ms + 32'd1;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // PWM divider, period counter and period-aligned shadow duties
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div   <= '0;
      r_pwm   <= 8'd0;
      r_act_r <= 8'd0;
      r_act_g <= 8'd0;
      r_act_b <= 8'd0;
    end else begin
      if (w_div_wrap) begin
        r_div <= '0;
        r_pwm <= r_pwm + 8'd1;
      end else begin
        r_div <= r_div + 1'b1;
      end
      if (w_pwm_wrap) begin
        r_act_r <= r_duty[7:0];
        r_act_g <= r_duty[15:8];
        r_act_b <= r_duty[23:16];
      end
    end
  end

  always_comb begin
    w_rd_mux = 32'd0;
    case (w_off)
      OFF_CTRL: w_rd_mux = {30'd0, r_ctrl};
      OFF_DUTY: w_rd_mux = {8'd0, r_duty};
      OFF_MS:   w_rd_mux = r_ms;
      OFF_ID:   w_rd_mux = ID_VALUE;
      default:  w_rd_mux = 32'd0;
    endcase
  end

  // Read port: registered, samples pre-edge register values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= 32'd0;
      r_hit   <= 1'b0;
    end else begin
      r_rdata <= w_sel ? w_rd_mux : 32'd0;
      r_hit   <= w_sel;
    end
  end

  assign mem_rdata = r_rdata;
  assign mem_hit   = r_hit;
  assign led       = r_ctrl[1] ? r_ms[9] : r_ctrl[0];
  assign red       = ~(r_pwm < r_act_r);
  assign green     = ~(r_pwm < r_act_g);
  assign blue      = ~(r_pwm < r_act_b);

endmodule
